// File: rtl/priority_arbiter_rr.sv
// Single-owner request arbiter: fixed priority (MODE=0) or round-robin (MODE=1).
// The owner-done input is named release_in because "release" is a reserved word.
module priority_arbiter_rr #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         release_in,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);

  generate
    if ((W != $clog2(N)) || (N < 2) || (N > 32) || ((MODE != 0) && (MODE != 1))) begin : g_cfg_err
      $error("priority_arbiter_rr: illegal N/W/MODE combination");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [W-1:0] PTR_RST = W'(N - 1);
  localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         win_found_s;
  logic [W-1:0] win_idx_s;
  logic [W-1:0] cand_s;

  // Winner search: walk ptr, ptr-1, ... wrapping modulo N; first set request wins.
  always_comb begin
    int tmp;
    win_found_s = 1'b0;
    win_idx_s   = {W{1'b0}};
    cand_s      = {W{1'b0}};
    tmp         = 0;
    for (int k = 0; k < N; k++) begin
      tmp = int'(ptr_q) - k;
      if (tmp < 0) begin
        tmp = tmp + N;
      end else begin
        tmp = tmp;
      end
      cand_s = W'(tmp);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and output logic of the IDLE/GRANT controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && win_found_s) begin
          state_d = ST_GRANT;
          grant_d = ONE_N << win_idx_s;
          idx_d   = win_idx_s;
          valid_d = 1'b1;
          // The winner becomes the lowest priority for the next arbitration.
          if (MODE == 1) begin
            ptr_d = (win_idx_s == {W{1'b0}}) ? PTR_RST : (win_idx_s - W'(1));
          end else begin
            ptr_d = PTR_RST;
          end
        end else begin
          state_d = ST_IDLE;
          grant_d = {N{1'b0}};
          idx_d   = {W{1'b0}};
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!enable || release_in) begin
          state_d = ST_IDLE;
          grant_d = {N{1'b0}};
          idx_d   = {W{1'b0}};
          valid_d = 1'b0;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N{1'b0}};
        idx_d   = {W{1'b0}};
        valid_d = 1'b0;
        ptr_d   = PTR_RST;
      end
    endcase
  end

  // State, registered outputs and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= {N{1'b0}};
      idx_q   <= {W{1'b0}};
      valid_q <= 1'b0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: doc/priority_arbiter_rr.md
PRIORITY_ARBITER_RR -- requirements
Module: priority_arbiter_rr

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 2..32.
REQ-002 Parameter W, default 3: grant index width; SHALL equal ceil(log2(N)); any other value is a configuration error.
REQ-003 Parameter MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  arbitration enable; 0 aborts any grant and blocks new ones.
REQ-007 req  input  N  request vector; bit i = requester i.
REQ-008 release  input  1  current owner done; sampled only in state GRANT.
REQ-009 grant  output  N  registered one-hot grant; all zeros when no grant.
REQ-010 grant_idx  output  W  registered binary index of the granted line; 0 when no grant.
REQ-011 grant_valid  output  1  registered; 1 exactly when grant is non-zero.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT.
REQ-013 In IDLE with enable=1 and req!=0: winner selected combinationally; next edge loads grant, grant_idx and grant_valid=1, then enters GRANT. Latency is 1 cycle from req to grant_valid.
REQ-014 In IDLE with enable=0 or req=0: outputs stay 0 and the FSM stays in IDLE.
REQ-015 MODE=0: the highest set index wins (N-1 highest, 0 lowest).
REQ-016 MODE=1: a pointer ptr (W bits) sets priority order ptr, ptr-1, ... 0, N-1, ... ptr+1, wrapping modulo N. The first set bit in that order wins.
REQ-017 MODE=1: on each grant load, ptr SHALL update to (winner-1) mod N, so winner 0 sets ptr=N-1. This makes the last winner lowest priority in the next arbitration.
REQ-018 MODE=0: ptr is held at N-1 and unused; the FSM is otherwise identical.
REQ-019 In GRANT: grant, grant_idx and grant_valid are held constant regardless of req changes, including withdrawal of the granted request.
REQ-020 In GRANT with release=1 and enable=1: next edge clears all outputs and enters IDLE. Re-arbitration occurs no earlier than the following edge, giving a minimum 1-cycle gap with grant_valid=0 between grants.
REQ-021 In GRANT with enable=0: next edge clears all outputs and enters IDLE. This abort takes precedence over release, and ptr is not changed.
REQ-022 release in IDLE is ignored.
REQ-023 grant SHALL never have more than one bit set, and grant[grant_idx] = 1 whenever grant_valid = 1.
REQ-024 Outputs are driven at all times; there is no high-impedance output state.

Reset
REQ-025 While rst_n=0, independent of clk: state = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, ptr = N-1.
REQ-026 Reset asserted mid-GRANT clears outputs immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first arbitration SHALL behave like fixed priority in both modes.
REQ-028 No output, including ptr, holds an X after reset.

Verification
REQ-029 N=8, MODE=0, enable=1, req=8'b0010_1010 -> 1 cycle later grant=8'b0010_0000, grant_idx=5, grant_valid=1; held until release.
REQ-030 N=8, MODE=1, req held at 8'hFF, release pulsed each grant -> grant_idx sequence 7,6,5,...,0,7, with exactly one grant_valid=0 cycle between consecutive grants.
REQ-031 MODE=1, previous winner 2 so ptr=1, req=8'b0000_0101 -> grant_idx=0 (wins over 2); next arbitration with same req -> grant_idx=2.
REQ-032 In GRANT idx=3, req drops to 0 -> outputs unchanged; then enable=0 together with release=1 -> next cycle outputs 0, IDLE, ptr unchanged.
REQ-033 rst_n pulled low between clock edges while grant_valid=1 -> grant, grant_idx and grant_valid go to 0 before the next edge; after release of reset, req=8'b1000_0001 in MODE=1 -> grant_idx=7.
REQ-034 Randomised req/release/enable, N in {2,5,8,32}, both modes -> assertions of REQ-023 hold every cycle, and in MODE=1 any continuously held request is granted within N grants.
